// File: rtl/main_mem_pkg.sv
// Shared types and defaults for the main memory controller.
// The request struct is sized to REQ_ADDR_MAX / REQ_DATA_MAX, so instances
// may use ADDR_WIDTH and DATA_WIDTH up to 64 bits.
package main_mem_pkg;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_MEM_DEPTH  = 1024;
    localparam int DEF_LATENCY    = 4;

    localparam int REQ_ADDR_MAX   = 64;
    localparam int REQ_DATA_MAX   = 64;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    typedef struct packed {
        logic [REQ_ADDR_MAX-1:0] address;
        logic [REQ_DATA_MAX-1:0] data;
        logic                    is_write;
    } mem_req_t;

    // Counter load value on accept: the remaining WAIT cycles before RESP.
    function automatic logic [3:0] lat_load(input int lat);
        return 4'(lat - 1);
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM with read-before-write behaviour.
// rdata is registered every cycle from the presented address.
module mem_array #(
    parameter int DEPTH      = 1024,
    parameter int DATA_WIDTH = 32,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write on we, read the addressed word every cycle (old contents on a write).
    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/main_mem_ctrl.sv
// Fixed-latency main memory controller: accepts one read or write in IDLE,
// holds it for LATENCY cycles and completes with a one-cycle mem_ack.
// Optional feature macro: MEM_ERR_CHECK_EN (misaligned / out-of-range /
// both-enables requests are flagged, writes dropped, reads return 0).
module main_mem_ctrl
    import main_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MEM_DEPTH  = DEF_MEM_DEPTH,
    parameter int LATENCY    = DEF_LATENCY
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] mem_address,
    input  logic                  mem_read_enable,
    input  logic                  mem_write_enable,
    input  logic [DATA_WIDTH-1:0] mem_write_data,
    output logic [DATA_WIDTH-1:0] mem_read_data,
    output logic                  mem_ack,
    output logic                  mem_busy,
    output logic                  mem_error
);

    localparam int IDX_W = $clog2(MEM_DEPTH);

    state_t                state, state_nxt;
    logic [3:0]            cnt, cnt_nxt;
    mem_req_t              req;
    logic                  req_err;
    logic                  accept;
    logic                  in_err;
    logic                  in_resp;
    logic                  resp_read;
    logic                  ram_we;
    logic [IDX_W-1:0]      ram_addr;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic [DATA_WIDTH-1:0] rd_now;
    logic [DATA_WIDTH-1:0] rd_hold;
    logic                  unused_bits;

    assign accept = (state == IDLE) && (mem_read_enable || mem_write_enable);

`ifdef MEM_ERR_CHECK_EN
    assign in_err = (|mem_address[1:0])
                  | (|(mem_address >> (IDX_W + 2)))
                  | (mem_read_enable & mem_write_enable);
`else
    assign in_err = 1'b0;
`endif

    // Latch the request on accept so the bus may change while we work.
    always_ff @(posedge clk) begin
        if (rst) begin
            req     <= '0;
            req_err <= 1'b0;
        end else if (accept) begin
            req.address  <= REQ_ADDR_MAX'(mem_address);
            req.data     <= REQ_DATA_MAX'(mem_write_data);
            req.is_write <= mem_write_enable;
            req_err      <= in_err;
        end
    end

    // State and latency counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state: counter is loaded with LATENCY-1 and RESP is entered as it reaches 0.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = lat_load(LATENCY);
                    end
                end
            end
            WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1)
                    state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign in_resp   = (state == RESP);
    assign resp_read = in_resp && !req.is_write;

    // The RAM sees the live bus index in IDLE so read data is ready even at LATENCY 1.
    assign ram_addr = (state == IDLE) ? mem_address[IDX_W+1:2] : req.address[IDX_W+1:2];
    assign ram_we   = in_resp && req.is_write && !req_err && !rst;

    mem_array #(
        .DEPTH      (MEM_DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_array (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (req.data[DATA_WIDTH-1:0]),
        .rdata (ram_rdata)
    );

    assign rd_now = req_err ? '0 : ram_rdata;

    // Hold the last read result until the next read completes.
    always_ff @(posedge clk) begin
        if (rst)
            rd_hold <= '0;
        else if (resp_read)
            rd_hold <= rd_now;
    end

    assign mem_read_data = resp_read ? rd_now : rd_hold;
    assign mem_ack       = in_resp;
    assign mem_busy      = (state != IDLE);
    assign mem_error     = in_resp && req_err;

    assign unused_bits = ^{mem_address, req.address, req.data};

endmodule

// File: tb/tb_main_mem_ctrl.sv
// Bench for main_mem_ctrl: two instances (LATENCY 4 and LATENCY 1) driven by
// directed transactions; a transaction-level model predicts per-cycle outputs.
module tb_main_mem_ctrl;

    localparam int NC = 512;

`ifdef MEM_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0]       rst, re, we, ack, busy, err;
    logic [1:0][31:0] addr, wdata, rdata;

    main_mem_ctrl #(.LATENCY(4)) dut0 (
        .clk(clk), .rst(rst[0]), .mem_address(addr[0]),
        .mem_read_enable(re[0]), .mem_write_enable(we[0]),
        .mem_write_data(wdata[0]), .mem_read_data(rdata[0]),
        .mem_ack(ack[0]), .mem_busy(busy[0]), .mem_error(err[0])
    );

    main_mem_ctrl #(.LATENCY(1)) dut1 (
        .clk(clk), .rst(rst[1]), .mem_address(addr[1]),
        .mem_read_enable(re[1]), .mem_write_enable(we[1]),
        .mem_write_data(wdata[1]), .mem_read_data(rdata[1]),
        .mem_ack(ack[1]), .mem_busy(busy[1]), .mem_error(err[1])
    );

    // Model state: expected outputs per cycle, memory image, abort bookkeeping.
    bit          e_ack  [2][NC];
    bit          e_busy [2][NC];
    bit          e_err  [2][NC];
    bit          rd_upd [2][NC];
    logic [31:0] rd_val [2][NC];
    logic [31:0] mm     [2][1024];
    logic [31:0] cur_rd [2];
    int          a_t    [2];
    bit          a_wr   [2];
    int          a_idx  [2];
    logic [31:0] a_old  [2];

    int vectors     = 0;
    int miscompares = 0;

    function automatic int lat(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", nm, d, cyc, act, exp);
        end
    endtask

    task automatic model_accept(input int d, input int t, input bit w, input bit r,
                                input logic [31:0] a, input logic [31:0] dat);
        int L;
        int idx;
        bit e;
        L   = lat(d);
        idx = int'(a[11:2]);
        e   = ERR_EN && ((a[1:0] != 2'b00) || (a[31:12] != 20'd0) || (w && r));
        for (int c = t + 1; c <= t + L; c++) e_busy[d][c] = 1'b1;
        e_ack[d][t+L] = 1'b1;
        e_err[d][t+L] = e;
        a_t[d]   = t;
        a_wr[d]  = w && !e;
        a_idx[d] = idx;
        a_old[d] = mm[d][idx];
        if (w) begin
            if (!e) mm[d][idx] = dat;
        end else begin
            rd_upd[d][t+L] = 1'b1;
            rd_val[d][t+L] = e ? 32'd0 : mm[d][idx];
        end
    endtask

    // rc is the cycle rst is high; outputs are all zero from rc+1.
    task automatic model_abort(input int d, input int rc);
        for (int c = rc + 1; c <= a_t[d] + lat(d); c++) begin
            e_busy[d][c] = 1'b0;
            e_ack[d][c]  = 1'b0;
            e_err[d][c]  = 1'b0;
            rd_upd[d][c] = 1'b0;
        end
        rd_upd[d][rc+1] = 1'b1;
        rd_val[d][rc+1] = 32'd0;
        if (a_wr[d]) mm[d][a_idx[d]] = a_old[d];
    endtask

    // Every cycle after the first reset edge, compare both instances with the model.
    always @(negedge clk) begin
        if (cyc >= 1 && cyc < NC) begin
            for (int d = 0; d < 2; d++) begin
                if (rd_upd[d][cyc]) cur_rd[d] = rd_val[d][cyc];
                chk("ack",  d, 32'(ack[d]),  32'(e_ack[d][cyc]));
                chk("busy", d, 32'(busy[d]), 32'(e_busy[d][cyc]));
                chk("rdata", d, rdata[d], cur_rd[d]);
                if (e_ack[d][cyc]) chk("error", d, 32'(err[d]), 32'(e_err[d][cyc]));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input int d, input bit w, input bit r,
                         input logic [31:0] a, input logic [31:0] dat);
        we[d] = w; re[d] = r; addr[d] = a; wdata[d] = dat;
        model_accept(d, cyc, w, r, a, dat);
    endtask

    task automatic idle(input int d);
        we[d] = 1'b0;
        re[d] = 1'b0;
    endtask

    task automatic txn(input int d, input bit w, input bit r,
                       input logic [31:0] a, input logic [31:0] dat);
        issue(d, w, r, a, dat);
        step(lat(d));
        idle(d);
        step(1);
    endtask

    int t;

    initial begin
        cur_rd[0] = 32'd0;
        cur_rd[1] = 32'd0;
        rst = 2'b11; we = '0; re = '0; addr = '0; wdata = '0;
        step(3);
        rst = 2'b00;

        // Write 0xDEADBEEF to 0x10 accepted in cycle 10; ack only in cycle 14.
        while (cyc < 10) step(1);
        issue(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
        step(1);
        chk("busy_c11", 0, 32'(busy[0]), 32'd1);
        step(2);
        chk("noack_c13", 0, 32'(ack[0]), 32'd0);
        step(1);
        chk("ack_c14", 0, 32'(ack[0]), 32'd1);
        idle(0);
        step(1);
        chk("idle_c15", 0, 32'(busy[0]), 32'd0);

        txn(0, 1'b1, 1'b0, 32'h0, 32'hA5A50000);
        txn(0, 1'b1, 1'b0, 32'h8, 32'h08080808);
        txn(0, 1'b1, 1'b0, 32'hC, 32'h0C0C0C0C);

        // Read back 0x10: data with ack four cycles after accept.
        issue(0, 1'b0, 1'b1, 32'h10, 32'h0);
        step(4);
        chk("rd_deadbeef", 0, rdata[0], 32'hDEADBEEF);
        chk("rd_err0", 0, 32'(err[0]), 32'd0);
        idle(0);
        step(1);

        // Both enables: write wins (or is flagged), read data untouched.
        issue(0, 1'b1, 1'b1, 32'h8, 32'h1234);
        step(4);
        chk("both_rd_hold", 0, rdata[0], 32'hDEADBEEF);
`ifdef MEM_ERR_CHECK_EN
        chk("both_err", 0, 32'(err[0]), 32'd1);
`endif
        idle(0);
        step(1);
        txn(0, 1'b0, 1'b1, 32'h8, 32'h0);

        // Reset two cycles into a write to 0xC aborts it.
        issue(0, 1'b1, 1'b0, 32'hC, 32'hBAD0BAD0);
        t = cyc;
        step(2);
        rst[0] = 1'b1;
        model_abort(0, t + 2);
        step(1);
        rst[0] = 1'b0;
        idle(0);
        chk("abort_ack", 0, 32'(ack[0]), 32'd0);
        chk("abort_busy", 0, 32'(busy[0]), 32'd0);
        chk("abort_rd", 0, rdata[0], 32'd0);
        step(4);
        issue(0, 1'b0, 1'b1, 32'hC, 32'h0);
        step(4);
        chk("abort_kept", 0, rdata[0], 32'h0C0C0C0C);
        idle(0);
        step(1);

        txn(0, 1'b0, 1'b1, 32'h11, 32'h0);
        issue(0, 1'b0, 1'b1, 32'h1002, 32'h0);
        step(4);
`ifdef MEM_ERR_CHECK_EN
        chk("oor_err", 0, 32'(err[0]), 32'd1);
        chk("oor_rd", 0, rdata[0], 32'd0);
`else
        chk("oor_rd", 0, rdata[0], 32'hA5A50000);
`endif
        idle(0);
        step(1);
        txn(0, 1'b1, 1'b0, 32'h20, 32'h77665544);
        txn(0, 1'b0, 1'b1, 32'h20, 32'h0);

        // LATENCY 1 with enables held high: acks two cycles apart.
        issue(1, 1'b1, 1'b0, 32'h4, 32'h11111111);
        step(1);
        chk("l1_ack1", 1, 32'(ack[1]), 32'd1);
        addr[1] = 32'h8; wdata[1] = 32'h22222222;
        step(1);
        chk("l1_gap", 1, 32'(ack[1]), 32'd0);
        issue(1, 1'b1, 1'b0, 32'h8, 32'h22222222);
        step(1);
        chk("l1_ack2", 1, 32'(ack[1]), 32'd1);
        idle(1);
        step(1);
        txn(1, 1'b0, 1'b1, 32'h4, 32'h0);
        issue(1, 1'b0, 1'b1, 32'h8, 32'h0);
        step(1);
        chk("l1_rd8", 1, rdata[1], 32'h22222222);
        idle(1);
        step(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/main_mem_ctrl.md
MAIN_MEM_CTRL -- requirements
Module: main_mem_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: byte-address width of the memory-side request.
REQ-002 Parameter DATA_WIDTH, default 32: word width.
REQ-003 Parameter MEM_DEPTH, default 1024: words in the backing array, power of two.
REQ-004 Parameter LATENCY, default 4: cycles from request accept to mem_ack, legal range 1..15.
REQ-005 clk  input  1  single clock; all logic rising-edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 mem_address  input  ADDR_WIDTH  byte address from the cache.
REQ-008 mem_read_enable  input  1  read request.
REQ-009 mem_write_enable  input  1  write request (write-back/write-through from the cache).
REQ-010 mem_write_data  input  DATA_WIDTH  write word.
REQ-011 mem_read_data  output  DATA_WIDTH  read word, valid with mem_ack on reads.
REQ-012 mem_ack  output  1  one-cycle completion pulse.
REQ-013 mem_busy  output  1  high whenever the FSM is not IDLE.
REQ-014 mem_error  output  1  error flag, qualified by mem_ack.

Function
REQ-015 FSM states IDLE, WAIT, RESP; IDLE samples the enables; WAIT and RESP ignore them.
REQ-016 IDLE with either enable high: latch address, write data and op; go to WAIT with counter = LATENCY-1, or to RESP directly when LATENCY = 1.
REQ-017 WAIT: decrement the counter each cycle; at 0 go to RESP.
REQ-018 RESP: mem_ack = 1 for exactly one cycle; next state IDLE. Accept in cycle T yields ack in cycle T+LATENCY.
REQ-019 Word index = latched address bits [log2(MEM_DEPTH)+1:2]; bits [1:0] and higher bits ignored for indexing.
REQ-020 Write commits to the array on the RESP clock edge; no array change before RESP.
REQ-021 Read: mem_read_data is registered to array[index] in RESP and holds until the next read's RESP; writes leave it unchanged.
REQ-022 Both enables high in IDLE: write wins; no read is performed.
REQ-023 Requester drops its enables the cycle after mem_ack; an enable still high in IDLE starts a new transaction (back-to-back: accept in cycle T+LATENCY+1).
REQ-024 Read-after-write to the same index returns the newly written word.

Reset
REQ-025 rst high: state IDLE, counter 0, mem_ack 0, mem_busy 0, mem_error 0, mem_read_data 0, latched request cleared.
REQ-026 rst mid-transaction aborts it: no ack, no array write; array contents are not cleared by reset.

Configuration
REQ-027 Macro MEM_ERR_CHECK_EN defined: mem_error = 1 with mem_ack when the latched address is misaligned (bits [1:0] != 0), out of range (any bit above log2(MEM_DEPTH)+1 set), or both enables were high; a write with an error is dropped; a read with an error returns 0.
REQ-028 Macro undefined: mem_error tied 0; all requests execute per REQ-019/REQ-022.

Structure
REQ-029 Package main_mem_pkg holds the state enum (IDLE, WAIT, RESP), default parameter constants and the request struct (address, data, is_write).
REQ-030 Sub-module mem_array: single-port synchronous RAM, MEM_DEPTH x DATA_WIDTH, one write enable; instantiated once.

Verification
REQ-031 LATENCY=4, write 0xDEADBEEF to 0x0000_0010 in cycle 10 -> mem_ack cycle 14, mem_busy cycles 11-14, array[4] = 0xDEADBEEF.
REQ-032 Then read 0x0000_0010 -> mem_read_data = 0xDEADBEEF with mem_ack 4 cycles after accept; mem_error 0.
REQ-033 Both enables high, address 0x8, data 0x1234 -> write to array[2], mem_read_data unchanged; with MEM_ERR_CHECK_EN, mem_error = 1 and array[2] unchanged.
REQ-034 rst asserted 2 cycles after a write accept to 0xC -> no mem_ack, array[3] unchanged, all outputs 0 the cycle after rst.
REQ-035 LATENCY=1, enables held high for two transactions -> mem_ack every 2 cycles.
REQ-036 MEM_ERR_CHECK_EN, read 0x0000_1002 (MEM_DEPTH 1024) -> mem_ack with mem_error = 1, mem_read_data = 0.
